// File: rtl/icram_bist_pkg.sv
// Shared definitions for the instruction-cache RAM BIST controller:
// state encodings, data backgrounds and address-walk directions.
package icram_bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ME0   = 3'd1,
      ST_ME1   = 3'd2,
      ST_ME2   = 3'd3,
      ST_ME3   = 3'd4,
      ST_DRAIN = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   localparam logic [31:0] BG_ZERO = 32'h0000_0000;
   localparam logic [31:0] BG_ALT1 = 32'h5555_5555;
   localparam logic [31:0] BG_ALT2 = 32'h3333_3333;
   localparam logic [31:0] BG_NIB  = 32'h0F0F_0F0F;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   function automatic logic [31:0] bg_sel(input logic [1:0] mode);
      logic [31:0] pat;
      case (mode)
         2'b00:   pat = BG_ZERO;
         2'b01:   pat = BG_ALT1;
         2'b10:   pat = BG_ALT2;
         2'b11:   pat = BG_NIB;
         default: pat = BG_ZERO;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/icram_bist_addr_gen.sv
// Up/down word-address counter with load, count enable and a terminal-count
// flag (all ones when counting up, zero when counting down).
module icram_bist_addr_gen
   import icram_bist_pkg::*;
#(
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [AW-1:0] load_val,
   input  logic          en,
   input  logic          dir,
   output logic [AW-1:0] addr,
   output logic          tc
);

   // Address register: load has priority over counting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr <= {AW{1'b0}};
      end else if (load) begin
         addr <= load_val;
      end else if (en) begin
         addr <= (dir == DIR_UP) ? addr + AW'(1) : addr - AW'(1);
      end else begin
         addr <= addr;
      end
   end

   assign tc = (dir == DIR_UP) ? (addr == {AW{1'b1}}) : (addr == {AW{1'b0}});

endmodule

// File: rtl/icram_bist.sv
// March C- style BIST controller for the instruction-cache data RAM.
// Owns the RAM BIST port while test_mode is high and reports a sticky pass/fail.
module icram_bist
   import icram_bist_pkg::*;
#(
   parameter int IC_MSB = 13
) (
   input  logic            clk,
   input  logic            bist_reset,
   input  logic            test_mode,
   input  logic [1:0]      bist_mode,
   input  logic [63:0]     icram_dout,
   output logic [31:0]     bist_icu_din,
   output logic [1:0]      bist_icu_ram_we,
   output logic [IC_MSB:3] bist_icu_addr,
   output logic            bist_enable,
   output logic            icache_test_err_l,
   output logic            bist_done
);

   localparam int AW = IC_MSB - 2;

   state_t        state_r, state_nx;
   logic          phase_r, phase_nx;
   logic          tm_r;
   logic [31:0]   pat_r, pat_nx;
   logic [31:0]   din_nx;
   logic [1:0]    we_nx;
   logic          en_nx;
   logic          rd_r, rd_nx;
   logic [31:0]   exp_r, exp_nx;
   logic          cmp_v_r;
   logic [31:0]   cmp_exp_r;
   logic          err_nx, done_nx;
   logic          addr_load, addr_en, addr_dir, addr_tc;
   logic [AW-1:0] addr_ld_val;
   logic          start_s, abort_s, mismatch_s;

   assign start_s    = test_mode & ~tm_r;
   assign abort_s    = ~test_mode & (state_r != ST_IDLE) & (state_r != ST_DONE);
   assign mismatch_s = cmp_v_r & (icram_dout != {cmp_exp_r, cmp_exp_r});

   icram_bist_addr_gen #(.AW(AW)) u_addr_gen (
      .clk      (clk),
      .rst      (bist_reset),
      .load     (addr_load),
      .load_val (addr_ld_val),
      .en       (addr_en),
      .dir      (addr_dir),
      .addr     (bist_icu_addr),
      .tc       (addr_tc)
   );

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_nx    = state_r;
      phase_nx    = phase_r;
      pat_nx      = pat_r;
      din_nx      = bist_icu_din;
      we_nx       = 2'b00;
      en_nx       = bist_enable;
      rd_nx       = 1'b0;
      exp_nx      = exp_r;
      done_nx     = bist_done;
      err_nx      = mismatch_s ? 1'b0 : icache_test_err_l;
      addr_load   = 1'b0;
      addr_ld_val = {AW{1'b0}};
      addr_en     = 1'b0;
      addr_dir    = (state_r == ST_ME2) ? DIR_DN : DIR_UP;

      if (abort_s) begin
         state_nx = ST_IDLE;
         en_nx    = 1'b0;
         done_nx  = 1'b0;
         err_nx   = icache_test_err_l;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  state_nx  = ST_ME0;
                  pat_nx    = bg_sel(bist_mode);
                  din_nx    = bg_sel(bist_mode);
                  we_nx     = 2'b11;
                  en_nx     = 1'b1;
                  phase_nx  = 1'b0;
                  err_nx    = 1'b1;
                  done_nx   = 1'b0;
                  addr_load = 1'b1;
               end else begin
                  en_nx = 1'b0;
               end
            end
            ST_ME0: begin
               if (addr_tc) begin
                  state_nx  = ST_ME1;
                  rd_nx     = 1'b1;
                  exp_nx    = pat_r;
                  phase_nx  = 1'b0;
                  addr_load = 1'b1;
               end else begin
                  we_nx   = 2'b11;
                  din_nx  = pat_r;
                  addr_en = 1'b1;
               end
            end
            ST_ME1: begin
               if (!phase_r) begin
                  we_nx    = 2'b11;
                  din_nx   = ~pat_r;
                  phase_nx = 1'b1;
               end else if (addr_tc) begin
                  state_nx    = ST_ME2;
                  rd_nx       = 1'b1;
                  exp_nx      = ~pat_r;
                  phase_nx    = 1'b0;
                  addr_load   = 1'b1;
                  addr_ld_val = {AW{1'b1}};
               end else begin
                  rd_nx    = 1'b1;
                  exp_nx   = pat_r;
                  phase_nx = 1'b0;
                  addr_en  = 1'b1;
               end
            end
            ST_ME2: begin
               if (!phase_r) begin
                  we_nx    = 2'b11;
                  din_nx   = pat_r;
                  phase_nx = 1'b1;
               end else if (addr_tc) begin
                  state_nx  = ST_ME3;
                  rd_nx     = 1'b1;
                  exp_nx    = pat_r;
                  phase_nx  = 1'b0;
                  addr_load = 1'b1;
               end else begin
                  rd_nx    = 1'b1;
                  exp_nx   = ~pat_r;
                  phase_nx = 1'b0;
                  addr_en  = 1'b1;
               end
            end
            ST_ME3: begin
               if (addr_tc) begin
                  state_nx = ST_DRAIN;
               end else begin
                  rd_nx   = 1'b1;
                  exp_nx  = pat_r;
                  addr_en = 1'b1;
               end
            end
            ST_DRAIN: begin
               state_nx = ST_DONE;
               en_nx    = 1'b0;
               done_nx  = 1'b1;
            end
            ST_DONE: begin
               en_nx = 1'b0;
               if (!test_mode) begin
                  state_nx = ST_IDLE;
               end else begin
                  state_nx = ST_DONE;
               end
            end
            default: begin
               state_nx = ST_IDLE;
               en_nx    = 1'b0;
            end
         endcase
      end
   end

   // State, output and compare-pipeline registers; cmp_* lines up with icram_dout.
   always_ff @(posedge clk or posedge bist_reset) begin
      if (bist_reset) begin
         state_r           <= ST_IDLE;
         phase_r           <= 1'b0;
         tm_r              <= 1'b0;
         pat_r             <= 32'h0000_0000;
         bist_icu_din      <= 32'h0000_0000;
         bist_icu_ram_we   <= 2'b00;
         bist_enable       <= 1'b0;
         rd_r              <= 1'b0;
         exp_r             <= 32'h0000_0000;
         cmp_v_r           <= 1'b0;
         cmp_exp_r         <= 32'h0000_0000;
         icache_test_err_l <= 1'b1;
         bist_done         <= 1'b0;
      end else begin
         state_r           <= state_nx;
         phase_r           <= phase_nx;
         tm_r              <= test_mode;
         pat_r             <= pat_nx;
         bist_icu_din      <= din_nx;
         bist_icu_ram_we   <= we_nx;
         bist_enable       <= en_nx;
         rd_r              <= rd_nx;
         exp_r             <= exp_nx;
         cmp_v_r           <= rd_r;
         cmp_exp_r         <= exp_r;
         icache_test_err_l <= err_nx;
         bist_done         <= done_nx;
      end
   end

endmodule

// File: tb/tb_icram_bist.sv
// Self-checking bench for icram_bist (N=8): behavioural RAM with optional
// faults, and an operation-list reference model of the March C- run.
module tb_icram_bist;

   localparam int IC_MSB = 5;
   localparam int AW     = IC_MSB - 2;
   localparam int N      = 1 << AW;
   localparam int RUN    = 6 * N;

   logic            clk = 1'b0;
   logic            bist_reset;
   logic            test_mode;
   logic [1:0]      bist_mode;
   logic [63:0]     icram_dout = 64'h0;
   logic [31:0]     bist_icu_din;
   logic [1:0]      bist_icu_ram_we;
   logic [IC_MSB:3] bist_icu_addr;
   logic            bist_enable;
   logic            icache_test_err_l;
   logic            bist_done;

   int checks = 0;
   int errors = 0;
   int fault_sel = 0;  // 0 none, 1 bit37 stuck-at-1 @3, 2 write@4 flips bit0 @5

   logic [63:0] ram [N];
   logic [63:0] ram_rd;

   typedef struct {
      int          addr;
      bit          wr;
      logic [31:0] d;
      logic [63:0] exp;
   } op_t;
   op_t ops[$];

   icram_bist #(.IC_MSB(IC_MSB)) dut (
      .clk               (clk),
      .bist_reset        (bist_reset),
      .test_mode         (test_mode),
      .bist_mode         (bist_mode),
      .icram_dout        (icram_dout),
      .bist_icu_din      (bist_icu_din),
      .bist_icu_ram_we   (bist_icu_ram_we),
      .bist_icu_addr     (bist_icu_addr),
      .bist_enable       (bist_enable),
      .icache_test_err_l (icache_test_err_l),
      .bist_done         (bist_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bist_enable) begin
         ram_rd = ram[bist_icu_addr];
         if (fault_sel == 1 && bist_icu_addr == 3'd3) ram_rd[37] = 1'b1;
         icram_dout <= ram_rd;
         if (bist_icu_ram_we == 2'b11) begin
            ram[bist_icu_addr] <= {bist_icu_din, bist_icu_din};
            if (fault_sel == 2 && bist_icu_addr == 3'd4) ram[5] <= ram[5] ^ 64'd1;
         end
      end
   end

   function automatic logic [31:0] pat_of(input logic [1:0] m);
      case (m)
         2'b00:   return 32'h0000_0000;
         2'b01:   return 32'h5555_5555;
         2'b10:   return 32'h3333_3333;
         default: return 32'h0F0F_0F0F;
      endcase
   endfunction

   function automatic void push_op(input int a, input bit wr, input logic [31:0] d,
                                   input logic [63:0] e);
      op_t o;
      o.addr = a; o.wr = wr; o.d = d; o.exp = e;
      ops.push_back(o);
   endfunction

   // The march algorithm as an ordered list of RAM operations.
   function automatic void build_ops(input logic [31:0] p);
      ops.delete();
      for (int a = 0; a < N; a++) push_op(a, 1'b1, p, 64'h0);
      for (int a = 0; a < N; a++) begin
         push_op(a, 1'b0, 32'h0, {p, p});
         push_op(a, 1'b1, ~p, 64'h0);
      end
      for (int a = N - 1; a >= 0; a--) begin
         push_op(a, 1'b0, 32'h0, {~p, ~p});
         push_op(a, 1'b1, p, 64'h0);
      end
      for (int a = 0; a < N; a++) push_op(a, 1'b0, 32'h0, {p, p});
   endfunction

   // Index of the first read that returns wrong data under the given fault, or -1.
   function automatic int predict_first_bad(input int fault);
      logic [63:0] m [N];
      logic [63:0] v;
      for (int a = 0; a < N; a++) m[a] = 64'h0;
      for (int j = 0; j < ops.size(); j++) begin
         if (ops[j].wr) begin
            m[ops[j].addr] = {ops[j].d, ops[j].d};
            if (fault == 2 && ops[j].addr == 4) m[5][0] = ~m[5][0];
         end else begin
            v = m[ops[j].addr];
            if (fault == 1 && ops[j].addr == 3) v[37] = 1'b1;
            if (v !== ops[j].exp) return j;
         end
      end
      return -1;
   endfunction

   // Scenario driver: starts a run and checks every cycle up to stop_t.
   task automatic run_march(input logic [1:0] mode, input int fault, input int stop_t,
                            input int chg_t, input logic [1:0] chg_mode, input string tag);
      int   fb;
      logic exp_err;
      build_ops(pat_of(mode));
      fb = predict_first_bad(fault);
      fault_sel = fault;
      test_mode = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bist_mode = mode;
      test_mode = 1'b1;
      @(posedge clk);
      for (int t = 0; t <= stop_t; t++) begin
         @(negedge clk);
         exp_err = !(fb >= 0 && t >= fb + 2);
         checks++;
         if (icache_test_err_l !== exp_err) begin
            errors++;
            $display("FAIL %s err_l t=%0d got %b want %b", tag, t, icache_test_err_l, exp_err);
         end
         if (t < RUN) begin
            checks++;
            if (bist_icu_addr !== AW'(ops[t].addr) || bist_enable !== 1'b1 ||
                bist_icu_ram_we !== (ops[t].wr ? 2'b11 : 2'b00) || bist_done !== 1'b0) begin
               errors++;
               $display("FAIL %s op t=%0d got a=%0d we=%b en=%b done=%b want a=%0d wr=%b",
                        tag, t, bist_icu_addr, bist_icu_ram_we, bist_enable, bist_done,
                        ops[t].addr, ops[t].wr);
            end
            if (ops[t].wr) begin
               checks++;
               if (bist_icu_din !== ops[t].d) begin
                  errors++;
                  $display("FAIL %s din t=%0d got %h want %h", tag, t, bist_icu_din, ops[t].d);
               end
            end
         end else if (t == RUN) begin
            checks++;
            if (bist_enable !== 1'b1 || bist_icu_ram_we !== 2'b00 || bist_done !== 1'b0) begin
               errors++;
               $display("FAIL %s drain got en=%b we=%b done=%b want 1 00 0",
                        tag, bist_enable, bist_icu_ram_we, bist_done);
            end
         end else begin
            checks++;
            if (bist_enable !== 1'b0 || bist_icu_ram_we !== 2'b00 || bist_done !== 1'b1) begin
               errors++;
               $display("FAIL %s done t=%0d got en=%b we=%b done=%b want 0 00 1",
                        tag, t, bist_enable, bist_icu_ram_we, bist_done);
            end
         end
         if (t == chg_t) bist_mode = chg_mode;
      end
      if (stop_t > RUN) begin
         test_mode = 1'b0;
         @(negedge clk);
         @(negedge clk);
         checks++;
         if (bist_done !== 1'b1 || icache_test_err_l !== (fb < 0) || bist_enable !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_hold got done=%b err_l=%b en=%b want 1 %b 0",
                     tag, bist_done, icache_test_err_l, bist_enable, (fb < 0));
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (bist_icu_din !== 32'h0 || bist_icu_ram_we !== 2'b00 || bist_icu_addr !== 3'd0 ||
          bist_enable !== 1'b0 || icache_test_err_l !== 1'b1 || bist_done !== 1'b0) begin
         errors++;
         $display("FAIL reset got din=%h we=%b a=%0d en=%b err_l=%b done=%b", bist_icu_din,
                  bist_icu_ram_we, bist_icu_addr, bist_enable, icache_test_err_l, bist_done);
      end
      bist_reset = 1'b0;
   endtask

   task automatic test_good_run();
      run_march(2'b01, 0, RUN + 2, -1, 2'b00, "good01");
      run_march(2'($urandom_range(0, 3)), 0, RUN + 2, -1, 2'b00, "good_rnd");
   endtask

   task automatic test_stuck_fault();
      run_march(2'b00, 1, RUN + 2, -1, 2'b00, "stuck");
   endtask

   task automatic test_coupling_fault();
      run_march(2'b10, 2, RUN + 2, -1, 2'b00, "couple");
   endtask

   task automatic test_abort();
      run_march(2'b01, 0, 20, -1, 2'b00, "abort");
      test_mode = 1'b0;
      @(negedge clk);
      checks++;
      if (bist_icu_ram_we !== 2'b00 || bist_enable !== 1'b0 || bist_done !== 1'b0 ||
          icache_test_err_l !== 1'b1) begin
         errors++;
         $display("FAIL abort_idle got we=%b en=%b done=%b err_l=%b want 00 0 0 1",
                  bist_icu_ram_we, bist_enable, bist_done, icache_test_err_l);
      end
      run_march(2'b01, 0, RUN + 2, -1, 2'b00, "rerun");
   endtask

   task automatic test_async_reset();
      run_march(2'b00, 1, 3 * N + 4, -1, 2'b00, "rst_pre");
      #2 bist_reset = 1'b1;
      #1;
      checks++;
      if (bist_icu_din !== 32'h0 || bist_icu_ram_we !== 2'b00 || bist_icu_addr !== 3'd0 ||
          bist_enable !== 1'b0 || icache_test_err_l !== 1'b1 || bist_done !== 1'b0) begin
         errors++;
         $display("FAIL async_rst got din=%h we=%b a=%0d en=%b err_l=%b done=%b", bist_icu_din,
                  bist_icu_ram_we, bist_icu_addr, bist_enable, icache_test_err_l, bist_done);
      end
      test_mode = 1'b0;
      fault_sel = 0;
      @(negedge clk);
      bist_reset = 1'b0;
   endtask

   task automatic test_mode_change();
      run_march(2'b01, 0, RUN + 2, N + 3, 2'b11, "mode_chg");
   endtask

   initial begin
      bist_reset = 1'b1;
      test_mode  = 1'b0;
      bist_mode  = 2'b00;
      for (int a = 0; a < N; a++) ram[a] = {$urandom, $urandom};
      test_reset();
      test_good_run();
      test_stuck_fault();
      test_coupling_fault();
      test_abort();
      test_async_reset();
      test_mode_change();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/icram_bist.md
# icram_bist

Built-in self-test controller for the instruction-cache data RAM. While `test_mode` is high it owns the RAM's BIST port: it drives the write data, write enables, address and power enable, and reads back `icram_dout`. It runs a four-element March C- style test with a data background chosen by `bist_mode`. The result goes to the test pins as `icache_test_err_l` and `bist_done`.

## Interface
- `IC_MSB`, default 13: MSB of the RAM address. The word address is `[IC_MSB:3]`, giving N = 2^(IC_MSB-2) 64-bit words.
- `clk` input 1: single clock; all state changes on the rising edge.
- `bist_reset` input 1: asynchronous, active-high reset.
- `test_mode` input 1: BIST request. A 0→1 transition starts a run; dropping to 0 aborts the run.
- `bist_mode` input 2: background select. 00=0000_0000, 01=5555_5555, 10=3333_3333, 11=0F0F_0F0F (32-bit pattern P).
- `icram_dout` input 64: RAM read data, valid one cycle after the address is presented.
- `bist_icu_din` output 32: write data.
- `bist_icu_ram_we` output 2: write enable, one bit per 32-bit half. The controller only ever drives 00 (read) or 11 (write `din` to both halves).
- `bist_icu_addr` output `[IC_MSB:3]`: word address.
- `bist_enable` output 1: RAM enable, high while running.
- `icache_test_err_l` output 1: sticky fail flag, active-low.
- `bist_done` output 1: run completed; held until the next start or reset.

## Operation
- States: IDLE, ME0, ME1, ME2, ME3, DRAIN, DONE.
- IDLE→ME0 on the edge where registered `test_mode` goes 0→1.
  - On that edge, clear `icache_test_err_l` to 1 and `bist_done` to 0, and set the address to 0.
- ME0, ascending: write P at every address, one word per cycle.
- ME1, ascending: per address, cycle A reads (we=00), cycle A+1 writes ~P (we=11).
  - Compare data for ME1 is {P,P}.
- ME2, descending from N-1 to 0: the same read/write pairs. Compare data is {~P,~P}; write data is P.
- ME3, ascending: read every address, one per cycle, compare data {P,P}.
- DRAIN: one cycle to compare the last ME3 read. Then go to DONE and set `bist_done`=1.
- Compare rule: in the cycle after each read, compare `icram_dout` against the expected 64-bit value.
  - On a mismatch, `icache_test_err_l` goes low on the next edge and stays low (sticky).
- DONE holds until `test_mode` falls, then returns to IDLE. `bist_done` and `icache_test_err_l` hold their values in IDLE.
- `test_mode` falling in any state other than IDLE or DONE aborts the run:
  - Go to IDLE the next edge, with we=00 and `bist_enable`=0.
  - `bist_done` stays 0 and the error flag keeps its value.
- A re-assertion of `test_mode` restarts from ME0. `bist_mode` is latched at start; changes during a run are ignored.
- Address counter wrap-around:
  - The ascending terminal count is N-1, the descending terminal count is 0.
  - The element change happens on the terminal-count cycle; there is no idle cycle between elements.

## Timing
- Reset values: state IDLE, `bist_icu_din`=0, `bist_icu_ram_we`=00, `bist_icu_addr`=0, `bist_enable`=0, `icache_test_err_l`=1, `bist_done`=0.
- All outputs are registered.
- RAM read latency is one cycle. The compare pipeline register holds the expected value aligned with `icram_dout`.
- Run length: the start edge is E0. ME0 takes N cycles, ME1 2N, ME2 2N, ME3 N, DRAIN 1. `bist_done` is high after edge E0+6N+1.
- Error latency: a mismatch on `icram_dout` in cycle k gives `icache_test_err_l`=0 after edge k+1.
- `bist_reset` mid-run forces the reset values immediately, without waiting for a clock edge.

## Structure
- A shared package or header holds:
  - state encodings (3 bits);
  - the four background constants;
  - element-direction constants.
- One sub-module, `icram_bist_addr_gen`: an up/down address counter with load, enable, direction and terminal-count output.
- The top level holds the FSM, the read/write phase toggle, the pattern select and the compare/error register.

## Test plan
- Good RAM model, IC_MSB=5 (N=8), `bist_mode`=01, raise `test_mode` → `bist_done`=1 after edge E0+49, `icache_test_err_l`=1 throughout; address trace 0..7, 0,0..7,7, 7,7..0,0, 0..7.
- RAM bit 37 stuck-at-1 at address 3, `bist_mode`=00 → `icache_test_err_l` falls on the first ME1 compare at address 3 and stays low; `bist_done` still rises at E0+49.
- Coupling fault: a write to address 4 flips bit 0 of address 5, `bist_mode`=10 → error detected in ME1 at address 5; flag stays low through DONE.
- Drop `test_mode` at E0+20 → IDLE next edge, we=00, `bist_enable`=0, `bist_done`=0; re-raise → clean run completes at new E0+49.
- Assert `bist_reset` mid-ME2 with the error flag low → all outputs return to reset values asynchronously, `icache_test_err_l`=1.
- `bist_mode` changed from 01 to 11 during ME1 → writes and compares continue using 5555_5555; no false error.
